jzjpcc_decode_execute_reg: RTL and testbench
============================================

// Module: jzjpcc_decode_execute_reg
// PURPOSE
//  Parametrised decode->execute pipeline register, successor to the fixed decode-stage output latch.
//  Adds valid tracking, hold (execute stall), bubble insertion (decode stall), flush and writeback->decode operand bypass.
//  Bypass also refreshes held operands. A saturating bubble counter is included for performance monitoring.
//  Sits between the decode logic (control + immediate former + register file read) and the execute stage.
// PARAMETERS
//  PC_MAX_B    31  MSB of word-aligned PC; PC fields are [PC_MAX_B:2]
//  CTRL_W       6  width of non-flushable control bundle (aluOperation, aluMod, aluMuxMode, rdSource, ...)
//  WB_BYPASS    1  1 = forward writeback data into rs1/rs2 on address match; 0 = pass register file data as-is
//  COUNT_W     16  width of bubble counter
// PORTS
//  clock                     in   1           rising-edge clock
//  reset                     in   1           synchronous, active-low reset (0 = reset, sampled on clock edge)
//  instruction_decode        in   30 [31:2]   instruction; rdAddr=[11:7], funct3=[14:12]
//  currentPC_decode          in   PC_MAX_B-1  PC of decode instruction
//  ctrl_decode               in   CTRL_W      control bundle from decoder
//  rdWriteEnable_decode      in   1           flushable control
//  memoryWriteEnable_decode  in   1           flushable control
//  immediate_decode          in   32          formed immediate
//  rs1Addr_decode            in   5           = instruction_decode[19:15]
//  rs2Addr_decode            in   5           = instruction_decode[24:20]
//  rs1_decode, rs2_decode    in   32 each     register file read data
//  rdWriteEnable_writeback   in   1           writeback stage writing rd this cycle
//  rdAddr_writeback          in   5           writeback destination
//  rdData_writeback          in   32          writeback data
//  stall_decode              in   1           hazard unit: decode instruction not ready, insert bubble
//  stall_execute             in   1           hazard unit: execute busy, hold register
//  flush_execute             in   1           hazard unit: kill instruction entering/held in execute
//  valid_execute             out  1           register holds a live instruction
//  rdWriteEnable_execute     out  1
//  memoryWriteEnable_execute out  1
//  ctrl_execute              out  CTRL_W
//  rdAddr_execute            out  5
//  funct3_execute            out  3
//  immediate_execute         out  32
//  currentPC_execute         out  PC_MAX_B-1
//  rs1_execute, rs2_execute  out  32 each
//  rs1Addr_execute           out  5           for hazard unit forwarding
//  rs2Addr_execute           out  5
//  bubbleCount               out  COUNT_W     saturating bubble count
// BEHAVIOUR
//  - Reset (reset==0 at posedge): every output register = 0, bubbleCount = 0.
//  - All outputs registered; latency 1 cycle. Action per edge, highest priority first:
//    1 flush_execute: valid/rdWriteEnable/memoryWriteEnable <= 0; other fields load decode values (don't-care).
//      Overrides stall_execute.
//    2 stall_execute: all fields hold; only operand refresh (below) may change rs1/rs2.
//    3 stall_decode: bubble; valid/rdWriteEnable/memoryWriteEnable <= 0; other fields load.
//    4 otherwise: load; valid <= 1, all fields from decode inputs.
//  - Load bypass (WB_BYPASS=1): rs1 <= rdData_writeback when all three hold:
//    rdWriteEnable_writeback, rdAddr_writeback==rs1Addr_decode, rs1Addr_decode!=0.
//    Otherwise rs1 <= rs1_decode. Same rule for rs2. Applies in cases 1, 3 and 4.
//  - Hold refresh (WB_BYPASS=1, case 2): if rdWriteEnable_writeback and rdAddr_writeback==rs1Addr_execute!=0,
//    rs1_execute <= rdData_writeback; same for rs2. Both operands may refresh in one cycle.
//  - WB_BYPASS=0: rs1/rs2 <= register file data on load, unchanged on hold.
//  - x0 never bypassed; rs values for address 0 come straight from rs*_decode.
//  - bubbleCount increments by 1 on each edge taking case 1 or 3. Saturates at 2^COUNT_W-1 (no wrap).
//  - Simultaneous stall_decode+stall_execute: hold wins; no bubble counted.
//  - Reset asserted mid-hold or mid-flush: reset wins; next cycle after release is a normal load.
// TESTING
//  - Reset: drive reset=0 with random inputs -> all outputs 0 after edge, bubbleCount=0.
//  - Load: instr=0x00A30293-style, rdWE=1, rs1_decode=0x11 -> next cycle valid=1, rdWriteEnable=1, rs1_execute=0x11, rdAddr=5.
//  - Bypass: rs1Addr_decode=7, wb rdAddr=7, rdWE_wb=1, rdData=0xDEADBEEF -> rs1_execute=0xDEADBEEF.
//    Repeat with addr 0 -> rs1_decode passed.
//  - Hold+refresh: stall_execute=1 for 3 cycles, wb writes rs2Addr_execute with 0x1234 in cycle 2 -> fields constant, rs2_execute=0x1234 from cycle 3.
//  - Flush vs hold: stall_execute=1 and flush_execute=1 same edge -> valid=0, rdWriteEnable=0, memoryWriteEnable=0, bubbleCount+1.
//  - Saturation: COUNT_W=2, 5 consecutive stall_decode cycles -> bubbleCount 1,2,3,3,3.

Source files
------------

// File: rtl/jzjpcc_decode_execute_reg_if.sv
// jzjpcc_decode_execute_reg_if: decode/hazard/writeback inputs and execute-side outputs of the decode->execute register
interface jzjpcc_decode_execute_reg_if #(
   parameter int PC_MAX_B = 31,
   parameter int CTRL_W   = 6,
   parameter int COUNT_W  = 16
);
   logic [31:2]         instruction_decode;
   logic [PC_MAX_B:2]   currentPC_decode;
   logic [CTRL_W-1:0]   ctrl_decode;
   logic                rdWriteEnable_decode;
   logic                memoryWriteEnable_decode;
   logic [31:0]         immediate_decode;
   logic [4:0]          rs1Addr_decode;
   logic [4:0]          rs2Addr_decode;
   logic [31:0]         rs1_decode;
   logic [31:0]         rs2_decode;
   logic                rdWriteEnable_writeback;
   logic [4:0]          rdAddr_writeback;
   logic [31:0]         rdData_writeback;
   logic                stall_decode;
   logic                stall_execute;
   logic                flush_execute;
   logic                valid_execute;
   logic                rdWriteEnable_execute;
   logic                memoryWriteEnable_execute;
   logic [CTRL_W-1:0]   ctrl_execute;
   logic [4:0]          rdAddr_execute;
   logic [2:0]          funct3_execute;
   logic [31:0]         immediate_execute;
   logic [PC_MAX_B:2]   currentPC_execute;
   logic [31:0]         rs1_execute;
   logic [31:0]         rs2_execute;
   logic [4:0]          rs1Addr_execute;
   logic [4:0]          rs2Addr_execute;
   logic [COUNT_W-1:0]  bubbleCount;

   modport master (
      output instruction_decode, currentPC_decode, ctrl_decode, rdWriteEnable_decode,
             memoryWriteEnable_decode, immediate_decode, rs1Addr_decode, rs2Addr_decode,
             rs1_decode, rs2_decode, rdWriteEnable_writeback, rdAddr_writeback,
             rdData_writeback, stall_decode, stall_execute, flush_execute,
      input  valid_execute, rdWriteEnable_execute, memoryWriteEnable_execute, ctrl_execute,
             rdAddr_execute, funct3_execute, immediate_execute, currentPC_execute,
             rs1_execute, rs2_execute, rs1Addr_execute, rs2Addr_execute, bubbleCount
   );

   modport slave (
      input  instruction_decode, currentPC_decode, ctrl_decode, rdWriteEnable_decode,
             memoryWriteEnable_decode, immediate_decode, rs1Addr_decode, rs2Addr_decode,
             rs1_decode, rs2_decode, rdWriteEnable_writeback, rdAddr_writeback,
             rdData_writeback, stall_decode, stall_execute, flush_execute,
      output valid_execute, rdWriteEnable_execute, memoryWriteEnable_execute, ctrl_execute,
             rdAddr_execute, funct3_execute, immediate_execute, currentPC_execute,
             rs1_execute, rs2_execute, rs1Addr_execute, rs2Addr_execute, bubbleCount
   );
endinterface

// File: rtl/jzjpcc_decode_execute_reg.sv
// jzjpcc_decode_execute_reg: decode->execute pipeline register with hold, bubble, flush, writeback bypass and bubble counter
module jzjpcc_decode_execute_reg #(
   parameter int PC_MAX_B  = 31,
   parameter int CTRL_W    = 6,
   parameter int WB_BYPASS = 1,
   parameter int COUNT_W   = 16
) (
   input logic clock,
   input logic reset,
   jzjpcc_decode_execute_reg_if.slave bus
);
   localparam bit BYP = WB_BYPASS != 0;

   logic                hold, bubble, byp1, byp2, ref1, ref2;
   logic                valid_d, valid_q, rdwe_d, rdwe_q, mwe_d, mwe_q;
   logic [CTRL_W-1:0]   ctrl_d, ctrl_q;
   logic [4:0]          rd_d, rd_q, rs1a_d, rs1a_q, rs2a_d, rs2a_q;
   logic [2:0]          f3_d, f3_q;
   logic [31:0]         imm_d, imm_q, rs1_d, rs1_q, rs2_d, rs2_q;
   logic [PC_MAX_B:2]   pc_d, pc_q;
   logic [COUNT_W-1:0]  cnt_d, cnt_q;
   logic                unused_instr_bits;

   assign unused_instr_bits = ^{bus.instruction_decode[31:15], bus.instruction_decode[6:2]};

   // flush beats an execute stall; a decode stall only bubbles when execute is free
   assign hold   = bus.stall_execute & ~bus.flush_execute;
   assign bubble = bus.flush_execute | (bus.stall_decode & ~bus.stall_execute);

   assign byp1 = BYP & bus.rdWriteEnable_writeback & (bus.rdAddr_writeback == bus.rs1Addr_decode) & (bus.rs1Addr_decode != 5'd0);
   assign byp2 = BYP & bus.rdWriteEnable_writeback & (bus.rdAddr_writeback == bus.rs2Addr_decode) & (bus.rs2Addr_decode != 5'd0);
   assign ref1 = BYP & bus.rdWriteEnable_writeback & (bus.rdAddr_writeback == rs1a_q) & (rs1a_q != 5'd0);
   assign ref2 = BYP & bus.rdWriteEnable_writeback & (bus.rdAddr_writeback == rs2a_q) & (rs2a_q != 5'd0);

   always_comb begin
      valid_d = hold ? valid_q : ~bubble;
      rdwe_d  = hold ? rdwe_q  : bus.rdWriteEnable_decode & ~bubble;
      mwe_d   = hold ? mwe_q   : bus.memoryWriteEnable_decode & ~bubble;
      ctrl_d  = hold ? ctrl_q  : bus.ctrl_decode;
      rd_d    = hold ? rd_q    : bus.instruction_decode[11:7];
      f3_d    = hold ? f3_q    : bus.instruction_decode[14:12];
      imm_d   = hold ? imm_q   : bus.immediate_decode;
      pc_d    = hold ? pc_q    : bus.currentPC_decode;
      rs1a_d  = hold ? rs1a_q  : bus.rs1Addr_decode;
      rs2a_d  = hold ? rs2a_q  : bus.rs2Addr_decode;
      rs1_d   = hold ? (ref1 ? bus.rdData_writeback : rs1_q) : (byp1 ? bus.rdData_writeback : bus.rs1_decode);
      rs2_d   = hold ? (ref2 ? bus.rdData_writeback : rs2_q) : (byp2 ? bus.rdData_writeback : bus.rs2_decode);
      cnt_d   = (bubble && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= 1'b0;
         rdwe_q  <= 1'b0;
         mwe_q   <= 1'b0;
         ctrl_q  <= '0;
         rd_q    <= '0;
         f3_q    <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         rs1a_q  <= '0;
         rs2a_q  <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rdwe_q  <= rdwe_d;
         mwe_q   <= mwe_d;
         ctrl_q  <= ctrl_d;
         rd_q    <= rd_d;
         f3_q    <= f3_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         rs1a_q  <= rs1a_d;
         rs2a_q  <= rs2a_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.valid_execute             = valid_q;
   assign bus.rdWriteEnable_execute     = rdwe_q;
   assign bus.memoryWriteEnable_execute = mwe_q;
   assign bus.ctrl_execute              = ctrl_q;
   assign bus.rdAddr_execute            = rd_q;
   assign bus.funct3_execute            = f3_q;
   assign bus.immediate_execute         = imm_q;
   assign bus.currentPC_execute         = pc_q;
   assign bus.rs1_execute               = rs1_q;
   assign bus.rs2_execute               = rs2_q;
   assign bus.rs1Addr_execute           = rs1a_q;
   assign bus.rs2Addr_execute           = rs2a_q;
   assign bus.bubbleCount               = cnt_q;
endmodule

// File: tb/tb_jzjpcc_decode_execute_reg.sv
// tb_jzjpcc_decode_execute_reg: table-driven vectors plus reset/saturation sequences for the decode->execute register
module tb_jzjpcc_decode_execute_reg;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   jzjpcc_decode_execute_reg_if #(.PC_MAX_B(31), .CTRL_W(6), .COUNT_W(2)) bus ();

   jzjpcc_decode_execute_reg #(.PC_MAX_B(31), .CTRL_W(6), .WB_BYPASS(1), .COUNT_W(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [5:0]  ctrl;
      logic        rdwe, mwe;
      logic [31:0] imm, rs1, rs2;
      logic        wbwe;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic        sd, se, fl;
      logic        ev, erdwe, emwe;
      logic [31:0] ers1, ers2;
      logic [1:0]  ecnt;
   } vec_t;

   vec_t vecs[17];
   vec_t last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.instruction_decode       = v.instr[31:2];
      bus.currentPC_decode         = v.pc[31:2];
      bus.ctrl_decode              = v.ctrl;
      bus.rdWriteEnable_decode     = v.rdwe;
      bus.memoryWriteEnable_decode = v.mwe;
      bus.immediate_decode         = v.imm;
      bus.rs1Addr_decode           = v.instr[19:15];
      bus.rs2Addr_decode           = v.instr[24:20];
      bus.rs1_decode               = v.rs1;
      bus.rs2_decode               = v.rs2;
      bus.rdWriteEnable_writeback  = v.wbwe;
      bus.rdAddr_writeback         = v.wba;
      bus.rdData_writeback         = v.wbd;
      bus.stall_decode             = v.sd;
      bus.stall_execute            = v.se;
      bus.flush_execute            = v.fl;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      //          instr         pc        ctrl   rdwe mwe imm        rs1           rs2           wbwe wba    wbd           sd se fl  ev erdwe emwe ers1          ers2          ecnt
      vecs[0]  = '{32'h00A30293, 32'h100, 6'h15, 1, 0, 32'h0000000A, 32'h11,       32'h22,       0, 5'd0,  32'h0,        0, 0, 0, 1, 1, 0, 32'h11,       32'h22,       2'd0};
      vecs[1]  = '{32'h00138193, 32'h104, 6'h2A, 1, 1, 32'h00000001, 32'h55,       32'h66,       1, 5'd7,  32'hDEADBEEF, 0, 0, 0, 1, 1, 1, 32'hDEADBEEF, 32'h66,       2'd0};
      vecs[2]  = '{32'h00002483, 32'h108, 6'h01, 0, 0, 32'h00000000, 32'h77,       32'h88,       1, 5'd0,  32'hCAFEF00D, 0, 0, 0, 1, 0, 0, 32'h77,       32'h88,       2'd0};
      vecs[3]  = '{32'h00138193, 32'h10C, 6'h3F, 1, 0, 32'h00000001, 32'h99,       32'hAA,       0, 5'd7,  32'h00000BAD, 0, 0, 0, 1, 1, 0, 32'h99,       32'hAA,       2'd0};
      vecs[4]  = '{32'h00C286B3, 32'h110, 6'h0C, 1, 0, 32'h00000000, 32'h1,        32'h2,        1, 5'd12, 32'h0BADF00D, 0, 0, 0, 1, 1, 0, 32'h1,        32'h0BADF00D, 2'd0};
      vecs[5]  = '{32'h00A30293, 32'h200, 6'h33, 0, 1, 32'h00000FFF, 32'h333,      32'h444,      0, 5'd0,  32'h0,        0, 1, 0, 1, 1, 0, 32'h1,        32'h0BADF00D, 2'd0};
      vecs[6]  = '{32'h00A30293, 32'h200, 6'h33, 0, 1, 32'h00000FFF, 32'h333,      32'h444,      1, 5'd12, 32'h1234,     0, 1, 0, 1, 1, 0, 32'h1,        32'h1234,     2'd0};
      vecs[7]  = '{32'h00A30293, 32'h200, 6'h33, 0, 1, 32'h00000FFF, 32'h333,      32'h444,      0, 5'd0,  32'h0,        1, 1, 0, 1, 1, 0, 32'h1,        32'h1234,     2'd0};
      vecs[8]  = '{32'h00A30293, 32'h204, 6'h05, 1, 1, 32'h0000000A, 32'h11,       32'h22,       0, 5'd0,  32'h0,        0, 1, 1, 0, 0, 0, 32'h11,       32'h22,       2'd1};
      vecs[9]  = '{32'h00138193, 32'h208, 6'h06, 1, 1, 32'h00000001, 32'h5,        32'h6,        0, 5'd0,  32'h0,        0, 0, 0, 1, 1, 1, 32'h5,        32'h6,        2'd1};
      vecs[10] = '{32'h00C286B3, 32'h20C, 6'h07, 1, 1, 32'h00000000, 32'h1,        32'h2,        1, 5'd5,  32'hFEED,     1, 0, 0, 0, 0, 0, 32'hFEED,     32'h2,        2'd2};
      vecs[11] = '{32'h00002483, 32'h210, 6'h08, 1, 0, 32'h00000000, 32'h7,        32'h8,        0, 5'd0,  32'h0,        0, 0, 1, 0, 0, 0, 32'h7,        32'h8,        2'd3};
      vecs[12] = '{32'h00A30293, 32'h214, 6'h09, 1, 1, 32'h0000000A, 32'h31,       32'h32,       1, 5'd10, 32'hABCD,     1, 0, 0, 0, 0, 0, 32'h31,       32'hABCD,     2'd3};
      vecs[13] = '{32'h00A30293, 32'h218, 6'h0A, 1, 1, 32'h0000000A, 32'h31,       32'h32,       0, 5'd0,  32'h0,        1, 0, 0, 0, 0, 0, 32'h31,       32'h32,       2'd3};
      vecs[14] = '{32'h00A30293, 32'h21C, 6'h0B, 1, 1, 32'h0000000A, 32'h31,       32'h32,       0, 5'd0,  32'h0,        1, 0, 0, 0, 0, 0, 32'h31,       32'h32,       2'd3};
      vecs[15] = '{32'h00002483, 32'h220, 6'h0C, 1, 0, 32'h00000000, 32'h1,        32'h2,        0, 5'd0,  32'h0,        0, 0, 0, 1, 1, 0, 32'h1,        32'h2,        2'd3};
      vecs[16] = '{32'h00002483, 32'h224, 6'h0D, 0, 1, 32'h00000000, 32'h9,        32'h9,        1, 5'd0,  32'hFFFF,     0, 1, 0, 1, 1, 0, 32'h1,        32'h2,        2'd3};

      // reset with random inputs
      bus.instruction_decode       = 30'($urandom);
      bus.currentPC_decode         = 30'($urandom);
      bus.ctrl_decode              = 6'($urandom);
      bus.rdWriteEnable_decode     = 1'b1;
      bus.memoryWriteEnable_decode = 1'b1;
      bus.immediate_decode         = $urandom;
      bus.rs1Addr_decode           = 5'($urandom);
      bus.rs2Addr_decode           = 5'($urandom);
      bus.rs1_decode               = $urandom;
      bus.rs2_decode               = $urandom;
      bus.rdWriteEnable_writeback  = 1'($urandom);
      bus.rdAddr_writeback         = 5'($urandom);
      bus.rdData_writeback         = $urandom;
      bus.stall_decode             = 1'b1;
      bus.stall_execute            = 1'b0;
      bus.flush_execute            = 1'b1;
      reset = 1'b0;
      step();
      chk("rst_valid", 32'(bus.valid_execute), 32'h0);
      chk("rst_rdwe", 32'(bus.rdWriteEnable_execute), 32'h0);
      chk("rst_mwe", 32'(bus.memoryWriteEnable_execute), 32'h0);
      chk("rst_ctrl", 32'(bus.ctrl_execute), 32'h0);
      chk("rst_rd", 32'(bus.rdAddr_execute), 32'h0);
      chk("rst_f3", 32'(bus.funct3_execute), 32'h0);
      chk("rst_imm", bus.immediate_execute, 32'h0);
      chk("rst_pc", 32'(bus.currentPC_execute), 32'h0);
      chk("rst_rs1", bus.rs1_execute, 32'h0);
      chk("rst_rs2", bus.rs2_execute, 32'h0);
      chk("rst_rs1a", 32'(bus.rs1Addr_execute), 32'h0);
      chk("rst_rs2a", 32'(bus.rs2Addr_execute), 32'h0);
      chk("rst_cnt", 32'(bus.bubbleCount), 32'h0);
      reset = 1'b1;

      last = vecs[0];
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i]);
         if (!(vecs[i].se && !vecs[i].fl)) last = vecs[i];
         step();
         chk($sformatf("v%0d_valid", i), 32'(bus.valid_execute), 32'(vecs[i].ev));
         chk($sformatf("v%0d_rdwe", i), 32'(bus.rdWriteEnable_execute), 32'(vecs[i].erdwe));
         chk($sformatf("v%0d_mwe", i), 32'(bus.memoryWriteEnable_execute), 32'(vecs[i].emwe));
         chk($sformatf("v%0d_rs1", i), bus.rs1_execute, vecs[i].ers1);
         chk($sformatf("v%0d_rs2", i), bus.rs2_execute, vecs[i].ers2);
         chk($sformatf("v%0d_cnt", i), 32'(bus.bubbleCount), 32'(vecs[i].ecnt));
         chk($sformatf("v%0d_rd", i), 32'(bus.rdAddr_execute), 32'(last.instr[11:7]));
         chk($sformatf("v%0d_f3", i), 32'(bus.funct3_execute), 32'(last.instr[14:12]));
         chk($sformatf("v%0d_rs1a", i), 32'(bus.rs1Addr_execute), 32'(last.instr[19:15]));
         chk($sformatf("v%0d_rs2a", i), 32'(bus.rs2Addr_execute), 32'(last.instr[24:20]));
         chk($sformatf("v%0d_pc", i), {bus.currentPC_execute, 2'b00}, last.pc);
         chk($sformatf("v%0d_imm", i), bus.immediate_execute, last.imm);
         chk($sformatf("v%0d_ctrl", i), 32'(bus.ctrl_execute), 32'(last.ctrl));
      end

      // reset asserted during a hold wins, then a normal load follows
      drive(vecs[5]);
      reset = 1'b0;
      step();
      chk("rhold_valid", 32'(bus.valid_execute), 32'h0);
      chk("rhold_rs1", bus.rs1_execute, 32'h0);
      chk("rhold_cnt", 32'(bus.bubbleCount), 32'h0);
      reset = 1'b1;
      drive(vecs[0]);
      step();
      chk("rload_valid", 32'(bus.valid_execute), 32'h1);
      chk("rload_rdwe", 32'(bus.rdWriteEnable_execute), 32'h1);
      chk("rload_rd", 32'(bus.rdAddr_execute), 32'h5);
      chk("rload_rs1", bus.rs1_execute, 32'h11);

      // counter saturation from zero over five bubbles
      reset = 1'b0;
      step();
      reset = 1'b1;
      drive(vecs[13]);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("sat%0d_cnt", i), 32'(bus.bubbleCount), (i < 3) ? i + 1 : 3);
         chk($sformatf("sat%0d_valid", i), 32'(bus.valid_execute), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
